lcd_dma_scheduler: RTL and testbench

Fetch scheduler for the LCD frame-buffer DMA. It shares one bus-master port between the upper-panel and lower-panel output FIFOs (lower is used only in dual-panel STN mode). It generates burst addresses from the panel base registers and restarts the address sequence on each frame start from the timing controller. It flags frames whose data was not fully fetched before the next frame start.

---
 rtl/lcd_dma_scheduler.sv | 164 ++++++++++++++++
 tb/tb_lcd_dma_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_dma_scheduler.sv
// LCD frame-buffer DMA fetch scheduler: shares one bus master between the upper and lower panel FIFOs.
// Optional macro LCD_DMA_1K_SPLIT_EN keeps every burst inside a single 1 KB address window.
module lcd_dma_scheduler #(
  parameter int LVLW = 6,
  parameter int CNTW = 20,
  parameter int LENW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            frame_start,
  input  logic            dual_en,
  input  logic [31:0]     upbase,
  input  logic [31:0]     lpbase,
  input  logic [CNTW-1:0] frame_words,
  input  logic [LENW-1:0] burst_len,
  input  logic [LVLW-1:0] watermark,
  input  logic [LVLW-1:0] up_level,
  input  logic [LVLW-1:0] lp_level,
  output logic            bus_req,
  output logic [31:0]     bus_addr,
  output logic [LENW-1:0] bus_len,
  input  logic            bus_gnt,
  input  logic            bus_done,
  output logic            data_sel,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, XFER} state_t;

  state_t          state, state_next;
  logic [31:0]     up_addr, lp_addr;
  logic [CNTW-1:0] up_rem, lp_rem;
  logic            rr;        // 1 = lower panel has priority on the next tie
  logic            pending;   // frame restart deferred until the in-flight burst ends

  logic            up_elig, lp_elig, pick_lower;
  logic [31:0]     sel_addr;
  logic [CNTW-1:0] sel_rem;
  logic [LENW-1:0] clamp_len, arb_len;
  logic            do_latch, do_complete, do_reload, set_pending;

  assign up_elig    = (up_rem != '0) && (up_level < watermark);
  assign lp_elig    = dual_en && (lp_rem != '0) && (lp_level < watermark);
  assign pick_lower = lp_elig && (!up_elig || rr);
  assign sel_addr   = pick_lower ? lp_addr : up_addr;
  assign sel_rem    = pick_lower ? lp_rem : up_rem;

`ifdef LCD_DMA_1K_SPLIT_EN
  logic [10:0] room_words;
  assign room_words = (11'd1024 - {1'b0, sel_addr[9:0]}) >> 2;
`endif

  always_comb begin
    clamp_len = burst_len;
    if (burst_len == '0)
      clamp_len = LENW'(1);
    else if (burst_len > LENW'(16))
      clamp_len = LENW'(16);
    arb_len = clamp_len;
    if (sel_rem < CNTW'(clamp_len))
      arb_len = LENW'(sel_rem);
`ifdef LCD_DMA_1K_SPLIT_EN
    if (room_words < 11'(arb_len))
      arb_len = LENW'(room_words);
`endif
  end

  always_comb begin
    state_next  = state;
    do_latch    = 1'b0;
    do_complete = 1'b0;
    do_reload   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_start)
          do_reload = 1'b1;
        else if (up_elig || lp_elig)
          state_next = ARB;
      end
      ARB: begin
        if (frame_start) begin
          do_reload  = 1'b1;
          state_next = IDLE;
        end else if (up_elig || lp_elig) begin
          do_latch   = 1'b1;
          state_next = REQ;
        end else begin
          state_next = IDLE;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          if (bus_done) begin
            do_complete = 1'b1;
            state_next  = IDLE;
          end else begin
            state_next = XFER;
          end
        end
      end
      XFER: begin
        if (bus_done) begin
          do_complete = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // A restart seen during a burst (earlier or in the completing cycle) replaces the counter update.
    if (do_complete)
      do_reload = pending || frame_start;
    set_pending = frame_start && ((state == REQ) || (state == XFER)) && !do_complete;
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      up_addr  <= '0;
      lp_addr  <= '0;
      up_rem   <= '0;
      lp_rem   <= '0;
      rr       <= 1'b0;
      pending  <= 1'b0;
      bus_addr <= '0;
      bus_len  <= '0;
      data_sel <= 1'b0;
    end else begin
      state <= state_next;
      if (do_latch) begin
        bus_addr <= sel_addr;
        bus_len  <= arb_len;
        data_sel <= pick_lower;
      end
      if (do_reload) begin
        up_addr <= upbase;
        lp_addr <= lpbase;
        up_rem  <= frame_words;
        lp_rem  <= dual_en ? frame_words : '0;
        rr      <= 1'b0;
        pending <= 1'b0;
      end else if (do_complete) begin
        if (data_sel) begin
          lp_addr <= lp_addr + (32'(bus_len) << 2);
          lp_rem  <= lp_rem - CNTW'(bus_len);
        end else begin
          up_addr <= up_addr + (32'(bus_len) << 2);
          up_rem  <= up_rem - CNTW'(bus_len);
        end
        rr      <= !data_sel;
        pending <= 1'b0;
      end else if (set_pending) begin
        pending <= 1'b1;
      end
    end
  end

  // Decoded from the state register so an async reset drops the request in the same instant.
  assign bus_req = (state == REQ);
  assign busy    = (state != IDLE);
  assign overrun = frame_start && ((up_rem != '0) || (lp_rem != '0));

endmodule

// File: tb/tb_lcd_dma_scheduler.sv
// Self-checking bench for lcd_dma_scheduler: vector table, hand-written corner sequences and a
// randomized run against a transaction-level burst model.
module tb_lcd_dma_scheduler;
  localparam int LVLW = 6;
  localparam int CNTW = 20;
  localparam int LENW = 5;

  logic            clk, reset, frame_start, dual_en;
  logic [31:0]     upbase, lpbase;
  logic [CNTW-1:0] frame_words;
  logic [LENW-1:0] burst_len;
  logic [LVLW-1:0] watermark, up_level, lp_level;
  logic            bus_req, bus_gnt, bus_done, data_sel, busy, overrun;
  logic [31:0]     bus_addr;
  logic [LENW-1:0] bus_len;

  lcd_dma_scheduler #(.LVLW(LVLW), .CNTW(CNTW), .LENW(LENW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .dual_en(dual_en),
    .upbase(upbase), .lpbase(lpbase), .frame_words(frame_words), .burst_len(burst_len),
    .watermark(watermark), .up_level(up_level), .lp_level(lp_level),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_len(bus_len),
    .bus_gnt(bus_gnt), .bus_done(bus_done), .data_sel(data_sel),
    .busy(busy), .overrun(overrun)
  );

  typedef struct packed {
    logic [31:0]     addr;
    logic [LENW-1:0] len;
    logic            sel;
  } burst_t;

  typedef struct {
    logic [31:0]     upbase;
    logic [31:0]     lpbase;
    int              fw;
    int              bl;
    logic            dual;
    int              n;
    burst_t [3:0]    exp;
  } vec_t;

  localparam int NV = 7;
  vec_t   vecs[NV];
  burst_t bursts[$];
  burst_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     overrun_cnt = 0;
  int     gnt_delay = 0;
  int     done_delay = 1;
  logic   rand_bus = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic burst_t mk(input logic [31:0] a, input int l, input logic s);
    return '{addr: a, len: LENW'(l), sel: s};
  endfunction

  // Transaction-level model: the list of bursts a whole frame must produce, in order.
  function automatic void build_expected(input logic [31:0] ub, input logic [31:0] lb,
                                         input int fw, input int bl, input logic dual);
    logic [31:0] ua, la, a;
    int          ur, lr, c, len, rem;
    logic        rr, sel;
    ua = ub; la = lb; ur = fw; lr = dual ? fw : 0; rr = 1'b0;
    c = (bl == 0) ? 1 : ((bl > 16) ? 16 : bl);
    exp_q.delete();
    while (ur > 0 || lr > 0) begin
      if (ur > 0 && lr > 0) sel = rr;
      else sel = (lr > 0);
      rem = sel ? lr : ur;
      a   = sel ? la : ua;
      len = (c < rem) ? c : rem;
`ifdef LCD_DMA_1K_SPLIT_EN
      begin
        int room;
        room = (1024 - int'(a % 1024)) / 4;
        if (room < len) len = room;
      end
`endif
      exp_q.push_back(mk(a, len, sel));
      if (sel) begin la = la + 32'(len * 4); lr = lr - len; end
      else begin ua = ua + 32'(len * 4); ur = ur - len; end
      rr = !sel;
    end
  endfunction

  // Bus slave: grants after gnt_delay cycles, signals done_delay cycles after the grant, logs each grant.
  initial begin : responder
    int gd, dd, waited;
    bus_gnt = 1'b0;
    bus_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !reset) begin
        gd = rand_bus ? int'($urandom_range(0, 3)) : gnt_delay;
        dd = rand_bus ? int'($urandom_range(0, 3)) : done_delay;
        waited = 0;
        while (waited < gd && bus_req) begin
          @(negedge clk);
          waited++;
        end
        if (bus_req) begin
          bus_gnt = 1'b1;
          bursts.push_back('{addr: bus_addr, len: bus_len, sel: data_sel});
          if (dd == 0) bus_done = 1'b1;
          @(negedge clk);
          bus_gnt = 1'b0;
          bus_done = 1'b0;
          if (dd > 0) begin
            repeat (dd - 1) @(negedge clk);
            bus_done = 1'b1;
            @(negedge clk);
            bus_done = 1'b0;
          end
        end
      end
    end
  end

  initial begin : overrun_mon
    forever begin
      @(negedge clk);
      #1;
      if (overrun) overrun_cnt++;
    end
  end

  task automatic start_frame();
    bursts.delete();
    overrun_cnt = 0;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic finish_and_compare(input string name, input int exp_ovr);
    int cyc;
    cyc = 0;
    while (!(bursts.size() >= exp_q.size() && !busy) && cyc < 5000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check({name, "_timeout"}, (cyc < 5000), 1);
    repeat (12) @(negedge clk);
    #1;
    check({name, "_count"}, bursts.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bursts.size(); i++)
      check($sformatf("%s_burst%0d", name, i), bursts[i], exp_q[i]);
    check({name, "_idle"}, {busy, bus_req}, 2'b00);
    check({name, "_overrun"}, overrun_cnt, exp_ovr);
  endtask

  task automatic apply_cfg(input logic [31:0] ub, input logic [31:0] lb, input int fw,
                           input int bl, input logic dual);
    upbase = ub; lpbase = lb; frame_words = CNTW'(fw); burst_len = LENW'(bl); dual_en = dual;
  endtask

  initial begin : main
    int   cyc;
    logic seen;
    reset = 1'b1; frame_start = 1'b0; dual_en = 1'b0; upbase = '0; lpbase = '0;
    frame_words = '0; burst_len = '0; watermark = 6'd8; up_level = '0; lp_level = '0;

    vecs[0] = '{32'h1000, 32'h0,    40, 16, 1'b0, 3, '0};
    vecs[0].exp[0] = mk(32'h1000, 16, 0); vecs[0].exp[1] = mk(32'h1040, 16, 0);
    vecs[0].exp[2] = mk(32'h1080, 8, 0);
    vecs[1] = '{32'h1000, 32'h8000, 32, 16, 1'b1, 4, '0};
    vecs[1].exp[0] = mk(32'h1000, 16, 0); vecs[1].exp[1] = mk(32'h8000, 16, 1);
    vecs[1].exp[2] = mk(32'h1040, 16, 0); vecs[1].exp[3] = mk(32'h8040, 16, 1);
`ifdef LCD_DMA_1K_SPLIT_EN
    vecs[2] = '{32'h13F0, 32'h0,    32, 16, 1'b0, 3, '0};
    vecs[2].exp[0] = mk(32'h13F0, 4, 0); vecs[2].exp[1] = mk(32'h1400, 16, 0);
    vecs[2].exp[2] = mk(32'h1440, 12, 0);
`else
    vecs[2] = '{32'h13F0, 32'h0,    32, 16, 1'b0, 2, '0};
    vecs[2].exp[0] = mk(32'h13F0, 16, 0); vecs[2].exp[1] = mk(32'h1430, 16, 0);
`endif
    vecs[3] = '{32'h2000, 32'h0,    3,  0,  1'b0, 3, '0};
    vecs[3].exp[0] = mk(32'h2000, 1, 0); vecs[3].exp[1] = mk(32'h2004, 1, 0);
    vecs[3].exp[2] = mk(32'h2008, 1, 0);
    vecs[4] = '{32'h3000, 32'h0,    20, 31, 1'b0, 2, '0};
    vecs[4].exp[0] = mk(32'h3000, 16, 0); vecs[4].exp[1] = mk(32'h3040, 4, 0);
    vecs[5] = '{32'h4000, 32'h5000, 0,  8,  1'b1, 0, '0};
    vecs[6] = '{32'h0100, 32'h0200, 5,  4,  1'b1, 4, '0};
    vecs[6].exp[0] = mk(32'h0100, 4, 0); vecs[6].exp[1] = mk(32'h0200, 4, 1);
    vecs[6].exp[2] = mk(32'h0110, 1, 0); vecs[6].exp[3] = mk(32'h0210, 1, 1);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_bus_req", bus_req, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_len", bus_len, 0);
    check("rst_data_sel", data_sel, 0);
    @(negedge clk);
    reset = 1'b0;

    // Vector table
    rand_bus = 1'b0; gnt_delay = 0; done_delay = 1;
    for (int v = 0; v < NV; v++) begin
      apply_cfg(vecs[v].upbase, vecs[v].lpbase, vecs[v].fw, vecs[v].bl, vecs[v].dual);
      exp_q.delete();
      for (int i = 0; i < vecs[v].n; i++) exp_q.push_back(vecs[v].exp[i]);
      start_frame();
      finish_and_compare($sformatf("vec%0d", v), 0);
    end

    // Watermark gating and request stability while the grant is withheld
    gnt_delay = 5; done_delay = 1;
    apply_cfg(32'h1000, 32'h0, 16, 4, 1'b0);
    up_level = 6'd8;
    start_frame();
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus_req) seen = 1'b1;
    end
    check("wm_blocked", seen, 0);
    @(negedge clk);
    up_level = 6'd7;
    #1;
    check("wm_idle", busy, 0);
    @(negedge clk);
    #1;
    check("wm_arb", {busy, bus_req}, 2'b10);
    @(negedge clk);
    #1;
    check("wm_req", {bus_req, bus_addr, bus_len}, {1'b1, 32'h1000, 5'd4});
    repeat (4) begin
      @(negedge clk);
      #1;
      check("wm_stable", {bus_req, bus_addr, bus_len}, {1'b1, 32'h1000, 5'd4});
    end
    up_level = '0;
    build_expected(32'h1000, 32'h0, 16, 4, 1'b0);
    finish_and_compare("watermark", 0);

    // frame_start twice during XFER: one deferred restart, two overrun pulses
    gnt_delay = 0; done_delay = 4;
    apply_cfg(32'h1000, 32'h0, 40, 16, 1'b0);
    start_frame();
    cyc = 0;
    while (bursts.size() == 0 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("fs_first_grant", (cyc < 100), 1);
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    check("fs_overrun_1", overrun, 1);
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    check("fs_overrun_2", {overrun, busy}, 2'b11);
    @(negedge clk);
    frame_start = 1'b0;
    exp_q.delete();
    exp_q.push_back(mk(32'h1000, 16, 0));
    exp_q.push_back(mk(32'h1000, 16, 0));
    exp_q.push_back(mk(32'h1040, 16, 0));
    exp_q.push_back(mk(32'h1080, 8, 0));
    finish_and_compare("fs_xfer", 2);

    // Reset while a request is outstanding
    gnt_delay = 20; done_delay = 1;
    apply_cfg(32'h1000, 32'h0, 16, 4, 1'b0);
    start_frame();
    cyc = 0;
    while (!bus_req && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("rq_reached", bus_req, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rq_rst_outputs", {bus_req, busy, data_sel, bus_len, bus_addr}, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("rq_no_grant", bursts.size(), 0);

    // Randomized frames against the burst model
    rand_bus = 1'b1;
    for (int it = 0; it < 25; it++) begin
      logic [31:0] ub, lb;
      int          fw, bl;
      logic        dl;
      ub = $urandom & 32'hFFFF_FFFC;
      lb = $urandom & 32'hFFFF_FFFC;
      fw = int'($urandom_range(0, 40));
      bl = int'($urandom_range(0, 31));
      dl = 1'($urandom_range(0, 1));
      watermark = 6'($urandom_range(1, 63));
      apply_cfg(ub, lb, fw, bl, dl);
      build_expected(ub, lb, fw, bl, dl);
      start_frame();
      finish_and_compare($sformatf("rand%0d", it), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
